easy_serial_out: RTL and testbench

Free-running 4-bit serializer for the first-simulation datapath. When enabled, it latches a parallel message and shifts it out MSB-first on a single serial line. It flags the first bit of every frame on a companion strobe, then idles for a programmable number of stand-by cycles before starting the next frame. It sits between message-producing logic and the serial channel.

---
 rtl/easy_serial_out.sv | 141 ++++++++++++++
 tb/tb_easy_serial_out.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/easy_serial_out.sv
// easy_serial_out: free-running MSB-first serializer.
// Each frame latches a parallel message, flags its first bit on state_send,
// shifts the bits out on state_out, then idles for a programmable number of
// stand-by cycles before loading the next frame. Dropping EN aborts the frame.
module easy_serial_out #(
    parameter int MSG_W = 4,
    parameter int SB_W  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [MSG_W-1:0] msg,
    input  logic [SB_W-1:0]  SB,
    output logic             state_send,
    output logic             state_out
);

    localparam int CNT_W = $clog2(MSG_W + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        STANDBY = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               load;
    logic [MSG_W-1:0]   shift_q;
    logic [MSG_W-1:0]   shift_nxt;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [SB_W-1:0]    sb_cnt_q;
    logic [SB_W-1:0]    sb_lat_q;
    logic               out_d;
    logic               send_d;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; also decides when a frame is (re)loaded.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (EN) begin
                    state_d = DATA;
                    load    = 1'b1;
                end
            end
            DATA: begin
                if (!EN) begin
                    state_d = IDLE;
                end else if (bit_cnt_q == '0) begin
                    // LSB has been on the line for one cycle: frame complete.
                    if (sb_lat_q != '0) begin
                        state_d = STANDBY;
                    end else begin
                        state_d = DATA;
                        load    = 1'b1;
                    end
                end
            end
            STANDBY: begin
                if (!EN) begin
                    state_d = IDLE;
                end else if (sb_cnt_q <= SB_W'(1)) begin
                    state_d = DATA;
                    load    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: next values for the registered serial line and strobe.
    always_comb begin
        shift_nxt = shift_q << 1;
        out_d     = 1'b0;
        send_d    = 1'b0;
        if (load) begin
            out_d  = msg[MSG_W-1];
            send_d = 1'b1;
        end else if (state_d == DATA) begin
            // Staying in DATA without a load means another bit of the
            // current frame is due; it is the MSB after this shift.
            out_d = shift_nxt[MSG_W-1];
        end
    end

    // Registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_out  <= 1'b0;
            state_send <= 1'b0;
        end else begin
            state_out  <= out_d;
            state_send <= send_d;
        end
    end

    // Message shift register, bit counter and stand-by length latch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            sb_lat_q  <= '0;
        end else if (load) begin
            shift_q   <= msg;
            sb_lat_q  <= SB;
            bit_cnt_q <= CNT_W'(MSG_W - 1);
        end else if (state_q == DATA && state_d == DATA) begin
            shift_q   <= shift_nxt;
            bit_cnt_q <= bit_cnt_q - CNT_W'(1);
        end
    end

    // Stand-by counter: loaded from the latched length, counts down to 1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sb_cnt_q <= '0;
        end else if (state_q == DATA && state_d == STANDBY) begin
            sb_cnt_q <= sb_lat_q;
        end else if (state_q == STANDBY && state_d == STANDBY) begin
            sb_cnt_q <= sb_cnt_q - SB_W'(1);
        end
    end

endmodule

// File: tb/tb_easy_serial_out.sv
// Testbench for easy_serial_out: expected line/strobe values are queued as
// stimulus is applied and compared one entry per clock after each edge.
module tb_easy_serial_out;

    localparam int MSG_W = 4;
    localparam int SB_W  = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             EN  = 1'b0;
    logic [MSG_W-1:0] msg = '0;
    logic [SB_W-1:0]  SB  = '0;
    logic             state_send;
    logic             state_out;

    typedef struct {
        logic out;
        logic send;
    } exp_t;

    exp_t  exp_q[$];
    int    n_total = 0;
    int    n_bad   = 0;
    string scen    = "reset";

    easy_serial_out #(.MSG_W(MSG_W), .SB_W(SB_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .msg        (msg),
        .SB         (SB),
        .state_send (state_send),
        .state_out  (state_out)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s/%s: got=%0h expected=%0h", scen, tag, got, want);
        end
    endtask

    task automatic push(input logic o, input logic s);
        exp_t e;
        e.out  = o;
        e.send = s;
        exp_q.push_back(e);
    endtask

    // One frame as seen on the line: MSB-first bits, strobe on the first, then sb zeros.
    task automatic push_frame(input logic [MSG_W-1:0] m, input int sb);
        for (int i = MSG_W - 1; i >= 0; i--) push(m[i], i == MSG_W - 1);
        for (int k = 0; k < sb; k++) push(1'b0, 1'b0);
    endtask

    // Advance n clocks, comparing outputs against the queue 1 time unit after each edge.
    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL %s/queue: got=empty expected=entry", scen);
            end else begin
                e = exp_q.pop_front();
                check("state_out", 32'(state_out), 32'(e.out));
                check("state_send", 32'(state_send), 32'(e.send));
            end
        end
    endtask

    // Drop EN for one edge to return to IDLE between scenarios.
    task automatic go_idle();
        EN = 1'b0;
        push(1'b0, 1'b0);
        run(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out", 32'(state_out), 32'd0);
        check("rst_send", 32'(state_send), 32'd0);
        RST = 1'b0;

        // Basic frame: 1,0,1,0 then 3 zeros, period 7.
        scen = "basic";
        msg = 4'b1010; SB = 4'd3; EN = 1'b1;
        push_frame(4'b1010, 3);
        push_frame(4'b1010, 3);
        run(14);
        go_idle();

        // msg is sampled only at load.
        scen = "msg_sample";
        msg = 4'b1100; SB = 4'd3; EN = 1'b1;
        push_frame(4'b1100, 3);
        push_frame(4'b0011, 3);
        run(1);
        msg = 4'b0011;
        run(13);
        go_idle();

        // SB=0: back-to-back frames, strobe every 4th cycle.
        scen = "sb_zero";
        msg = 4'b1001; SB = 4'd0; EN = 1'b1;
        push_frame(4'b1001, 0);
        push_frame(4'b1001, 0);
        push_frame(4'b1001, 0);
        run(12);
        go_idle();

        // Abort during the 2nd data bit, then restart from the new msg MSB.
        scen = "abort";
        msg = 4'b1011; SB = 4'd2; EN = 1'b1;
        push(1'b1, 1'b1);
        push(1'b0, 1'b0);
        run(2);
        EN = 1'b0;
        push(1'b0, 1'b0);
        push(1'b0, 1'b0);
        run(2);
        msg = 4'b1101; EN = 1'b1;
        push_frame(4'b1101, 2);
        run(6);
        go_idle();

        // SB=15 gap; changing SB mid-standby affects only the next frame.
        scen = "sb_max";
        msg = 4'b0111; SB = 4'hF; EN = 1'b1;
        push_frame(4'b0111, 15);
        push_frame(4'b0111, 2);
        run(9);
        SB = 4'd2;
        run(16);
        go_idle();

        // Asynchronous reset mid-frame, then fresh frame one edge after release.
        scen = "rst_mid";
        msg = 4'b1010; SB = 4'd3; EN = 1'b1;
        push(1'b1, 1'b1);
        push(1'b0, 1'b0);
        run(1);
        push(1'b1, 1'b0);
        run(2);
        #1;
        RST = 1'b1;
        #1;
        check("async_out", 32'(state_out), 32'd0);
        check("async_send", 32'(state_send), 32'd0);
        @(posedge CLK);
        #1;
        check("held_out", 32'(state_out), 32'd0);
        check("held_send", 32'(state_send), 32'd0);
        RST = 1'b0;
        push_frame(4'b1010, 3);
        run(7);
        go_idle();

        scen = "end";
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
